// File: rtl/mlp_stream_engine.sv
// Streaming binarised two-layer perceptron: loads one image as a pixel stream, evaluates
// LANES hidden neurons per cycle from an external weight memory, and returns a signed score.
module mlp_stream_engine #(
    parameter int INPUT_SIZE  = 4096,
    parameter int HIDDEN_SIZE = 128,
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT       = 0,
    parameter int AW          = $clog2((HIDDEN_SIZE / LANES) * INPUT_SIZE + 2 * (HIDDEN_SIZE / LANES) + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  logic [DATA_WIDTH-1:0]       pix_data,
    output logic                        pix_ready,
    input  logic [DATA_WIDTH-1:0]       threshold,
    output logic                        w_rd,
    output logic [AW-1:0]               w_addr,
    input  logic [LANES*DATA_WIDTH-1:0] w_data,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [ACC_WIDTH-1:0]        score,
    output logic                        defect,
    output logic                        busy
);

    localparam int G  = HIDDEN_SIZE / LANES;
    localparam int CW = $clog2(INPUT_SIZE + 2);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int HW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;

    localparam logic [CW-1:0] C_L1_LAST = CW'(INPUT_SIZE);
    localparam logic [CW-1:0] C_L1_WB   = CW'(INPUT_SIZE + 1);
    localparam logic [CW-1:0] C_L2_LAST = CW'(G);
    localparam logic [CW-1:0] C_L2_FIN  = CW'(G + 1);
    localparam logic signed [ACC_WIDTH-1:0] HMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {LOAD, L1, L2, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [GW-1:0]                grp;
    logic [PW-1:0]                pcnt;
    logic [INPUT_SIZE-1:0]        bits;
    logic [DATA_WIDTH-1:0]        hidden [HIDDEN_SIZE];
    logic signed [ACC_WIDTH-1:0]  acc    [LANES];

    logic signed [DATA_WIDTH-1:0] w_lane  [LANES];
    logic [DATA_WIDTH-1:0]        hid_new [LANES];
    logic signed [ACC_WIDTH-1:0]  l2_sum;
    logic signed [ACC_WIDTH-1:0]  l2_final;
    logic [PW-1:0]                l1_idx;
    int unsigned                  l2_k;
    logic                         accept;

    // Read data lags the strobe by one cycle, so a counter value c consumes the word issued at c-1.
    function automatic logic [AW:0] rd_word(input state_t st, input int unsigned c, input int unsigned g);
        logic [AW:0] r;
        r = '0;
        if (st == L1) begin
            if (c < INPUT_SIZE)       r = {1'b1, AW'(g * INPUT_SIZE + c)};
            else if (c == INPUT_SIZE) r = {1'b1, AW'(G * INPUT_SIZE + g)};
        end else if (st == L2) begin
            if (c < G)                r = {1'b1, AW'(G * INPUT_SIZE + G + c)};
            else if (c == G)          r = {1'b1, AW'(G * INPUT_SIZE + 2 * G)};
        end
        return r;
    endfunction

    assign accept = (state == LOAD) && pix_valid && pix_ready;

    always_comb begin
        logic signed [ACC_WIDTH-1:0] pre;
        l2_sum = '0;
        l1_idx = PW'(cnt - 1'b1);
        l2_k   = (cnt == '0) ? 0 : 32'(cnt) - 1;
        if (l2_k >= G) l2_k = 0;
        for (int unsigned n = 0; n < LANES; n++) begin
            w_lane[n] = w_data[n*DATA_WIDTH +: DATA_WIDTH];
            pre = acc[n] + ACC_WIDTH'(w_lane[n]);
            if (pre < 0) pre = '0;
            pre = pre >>> SHIFT;
            hid_new[n] = (pre > HMAX) ? DATA_WIDTH'(HMAX) : DATA_WIDTH'(pre);
            l2_sum = l2_sum + ACC_WIDTH'($signed({1'b0, hidden[HW'(l2_k * LANES + n)]})) * ACC_WIDTH'(w_lane[n]);
        end
        l2_final = $signed(score) + ACC_WIDTH'(w_lane[0]);
    end

    always_ff @(posedge clk) begin
        if (rst && accept) bits[pcnt] <= (pix_data >= threshold);
        if (rst && state == L1 && cnt == C_L1_WB)
            for (int unsigned n = 0; n < LANES; n++)
                hidden[HW'(32'(grp) * LANES + n)] <= hid_new[n];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LOAD;
            cnt          <= '0;
            grp          <= '0;
            pcnt         <= '0;
            score        <= '0;
            defect       <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            pix_ready    <= 1'b0;
            w_rd         <= 1'b0;
            w_addr       <= '0;
            for (int unsigned n = 0; n < LANES; n++) acc[n] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    pix_ready <= 1'b1;
                    if (accept) begin
                        if (pcnt == PW'(INPUT_SIZE - 1)) begin
                            pcnt            <= '0;
                            state           <= L1;
                            busy            <= 1'b1;
                            pix_ready       <= 1'b0;
                            cnt             <= '0;
                            grp             <= '0;
                            score           <= '0;
                            {w_rd, w_addr}  <= rd_word(L1, 0, 0);
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                L1: begin
                    if (cnt != '0 && cnt <= C_L1_LAST && bits[l1_idx])
                        for (int unsigned n = 0; n < LANES; n++) acc[n] <= acc[n] + ACC_WIDTH'(w_lane[n]);
                    if (cnt == C_L1_WB) begin
                        for (int unsigned n = 0; n < LANES; n++) acc[n] <= '0;
                        cnt <= '0;
                        if (grp == GW'(G - 1)) begin
                            state          <= L2;
                            {w_rd, w_addr} <= rd_word(L2, 0, 0);
                        end else begin
                            grp            <= grp + 1'b1;
                            {w_rd, w_addr} <= rd_word(L1, 0, 32'(grp) + 1);
                        end
                    end else begin
                        cnt            <= cnt + 1'b1;
                        {w_rd, w_addr} <= rd_word(L1, 32'(cnt) + 1, 32'(grp));
                    end
                end
                L2: begin
                    if (cnt != '0 && cnt <= C_L2_LAST) score <= $signed(score) + l2_sum;
                    if (cnt == C_L2_FIN) begin
                        score        <= l2_final;
                        defect       <= (l2_final > 0);
                        result_valid <= 1'b1;
                        state        <= DONE;
                        w_rd         <= 1'b0;
                    end else begin
                        cnt            <= cnt + 1'b1;
                        {w_rd, w_addr} <= rd_word(L2, 32'(cnt) + 1, 0);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        pix_ready    <= 1'b1;
                        pcnt         <= '0;
                        state        <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_stream_engine.sv
// Randomised bench for mlp_stream_engine: a neuron-by-neuron arithmetic model predicts
// every score, and a per-cycle monitor checks result timing, stability and the read stream.
module tb_mlp_stream_engine;

    localparam int IS      = 16;
    localparam int HS      = 4;
    localparam int L       = 2;
    localparam int DW      = 8;
    localparam int G       = HS / L;
    localparam int COMPUTE = G * (IS + 2) + G + 3;
    localparam int MW      = G * IS + 2 * G + 1;
    localparam int AWB     = $clog2(MW);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pix_valid = 1'b0;
    logic [DW-1:0]   pix_data = '0;
    logic            pix_ready;
    logic [DW-1:0]   threshold = '0;
    logic            w_rd;
    logic [AWB-1:0]  w_addr;
    logic [L*DW-1:0] w_data = '0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [31:0]     score;
    logic            defect;
    logic            busy;

    mlp_stream_engine #(
        .INPUT_SIZE (IS),
        .HIDDEN_SIZE(HS),
        .LANES      (L),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (32),
        .SHIFT      (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .threshold   (threshold),
        .w_rd        (w_rd),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .score       (score),
        .defect      (defect),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [L*DW-1:0] mem [MW];
    int  vectors = 0, miscompares = 0;
    int  cyc = 0;
    int  last_acc = -1000;
    bit  rv_prev = 1'b0;
    int  exp_score = 0;
    bit  exp_defect = 1'b0;
    int  addr_q[$];
    int  exp_addr[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers one cycle after the strobe; junk otherwise.
    always @(posedge clk) w_data <= w_rd ? mem[w_addr] : (L*DW)'($urandom);

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int wv(input int addr, input int lane);
        logic [DW-1:0] b;
        b = mem[addr][lane*DW +: DW];
        return int'($signed(b));
    endfunction

    function automatic int model_score(input logic [IS-1:0] b);
        int s, h, lane, grp;
        s = wv(G * IS + 2 * G, 0);
        for (int n = 0; n < HS; n++) begin
            grp  = n / L;
            lane = n % L;
            h = wv(G * IS + grp, lane);
            for (int i = 0; i < IS; i++) if (b[i]) h += wv(grp * IS + i, lane);
            if (h < 0) h = 0;
            if (h > 127) h = 127;
            s += h * wv(G * IS + G + grp, lane);
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst) rv_prev = 1'b0;
        else begin
            if (w_rd) begin
                addr_q.push_back(int'(w_addr));
                chk("w_rd_outside_busy", busy, 1);
            end
            if (result_valid) begin
                if (!rv_prev) chk("latency", cyc - last_acc, COMPUTE);
                chk("score", $signed(score), exp_score);
                chk("defect", defect, exp_defect);
                chk("pix_ready_in_done", pix_ready, 0);
                chk("busy_in_done", busy, 1);
            end else if (busy) begin
                chk("pix_ready_while_busy", pix_ready, 0);
            end
            rv_prev = result_valid;
        end
    end

    task automatic set_mem_const(input int w1, input int b1, input int w2, input int b2);
        for (int a = 0; a < MW; a++) begin
            if (a < G * IS)              mem[a] = {L{DW'(w1)}};
            else if (a < G * IS + G)     mem[a] = {L{DW'(b1)}};
            else if (a < G * IS + 2 * G) mem[a] = {L{DW'(w2)}};
            else                         mem[a] = {DW'($urandom), DW'(b2)};
        end
    endtask

    task automatic set_mem_rand();
        for (int a = 0; a < MW; a++) mem[a] = (L*DW)'($urandom);
    endtask

    task automatic send_image(input logic [DW-1:0] px [IS], input logic [DW-1:0] thr,
                              input bit rand_thr, input int gap_pct);
        logic [IS-1:0] b;
        int idx, guard;
        idx = 0;
        guard = 0;
        b = '0;
        while (idx < IS && guard < 2000) begin
            @(posedge clk);
            #1;
            pix_valid = ($urandom_range(99) >= gap_pct);
            pix_data  = pix_valid ? px[idx] : DW'($urandom);
            threshold = rand_thr ? DW'($urandom) : thr;
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                b[idx] = (pix_data >= threshold);
                if (idx == IS - 1) last_acc = cyc;
                idx++;
            end
            guard++;
        end
        chk("pixels_accepted", idx, IS);
        exp_score  = model_score(b);
        exp_defect = (exp_score > 0);
    endtask

    task automatic wait_result(input int hold);
        int g, bad;
        g = 0;
        while (!result_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("result_arrived", result_valid, 1);
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk("rv_after_handshake", result_valid, 0);
        chk("pix_ready_after_handshake", pix_ready, 1);
        chk("busy_after_handshake", busy, 0);
        chk("addr_count", addr_q.size(), exp_addr.size());
        if (addr_q.size() == exp_addr.size()) begin
            bad = -1;
            for (int i = 0; i < exp_addr.size(); i++)
                if (bad < 0 && addr_q[i] != exp_addr[i]) bad = i;
            chk("addr_seq_first_bad_index", bad, -1);
        end
        addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] px [IS];

        for (int g = 0; g < G; g++) begin
            for (int i = 0; i < IS; i++) exp_addr.push_back(g * IS + i);
            exp_addr.push_back(G * IS + g);
        end
        for (int k = 0; k < G; k++) exp_addr.push_back(G * IS + G + k);
        exp_addr.push_back(G * IS + 2 * G);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_score", score, 0);
        chk("rst_defect", defect, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w_rd", w_rd, 0);
        chk("rst_w_addr", w_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pix_ready_after_release", pix_ready, 1);
        addr_q.delete();

        set_mem_const(1, 5, 1, -30);
        for (int i = 0; i < IS; i++) px[i] = 8'h00;
        send_image(px, 8'h80, 1'b0, 0);
        chk("model_zero_image", exp_score, -10);
        wait_result(0);

        for (int i = 0; i < IS; i++) px[i] = 8'h80;
        send_image(px, 8'h80, 1'b0, 0);
        chk("model_equal_threshold", exp_score, 54);
        wait_result(0);

        set_mem_const(127, 5, 1, 0);
        for (int i = 0; i < IS; i++) px[i] = 8'hFF;
        send_image(px, 8'h80, 1'b0, 0);
        chk("model_saturation", exp_score, 508);
        wait_result(0);

        set_mem_const(0, -100, 1, 17);
        send_image(px, 8'h80, 1'b0, 30);
        chk("model_relu_floor", exp_score, 17);
        wait_result(3);

        for (int t = 0; t < 4; t++) begin
            set_mem_rand();
            for (int i = 0; i < IS; i++) px[i] = DW'($urandom);
            send_image(px, 8'h00, 1'b1, 40);
            wait_result(20);
        end

        set_mem_rand();
        for (int i = 0; i < IS; i++) px[i] = DW'($urandom);
        send_image(px, 8'h80, 1'b0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_w_rd", w_rd, 0);
        chk("midrun_rst_result_valid", result_valid, 0);
        chk("midrun_rst_pix_ready", pix_ready, 0);
        addr_q.delete();
        @(negedge clk);
        chk("midrun_load_pix_ready", pix_ready, 1);
        send_image(px, 8'h80, 1'b0, 0);
        wait_result(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
